// File: rtl/ingress_flit_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_REQ flit sources share one NoC ingress
// channel through a one-entry registered output stage with valid/ready.
module ingress_flit_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int EGRESS_BITS  = 64,
    parameter int PAYLOAD_BITS = 64,
    parameter int CNT_BITS     = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_head,
    input  logic [NUM_REQ-1:0]              req_tail,
    input  logic [NUM_REQ*EGRESS_BITS-1:0]  req_egress_id,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            out_valid,
    output logic                            out_head,
    output logic                            out_tail,
    output logic [EGRESS_BITS-1:0]          out_egress_id,
    output logic [PAYLOAD_BITS-1:0]         out_payload,
    input  logic                            out_ready,
    output logic [CNT_BITS-1:0]             pkt_count,
    output logic                            protocol_error
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PTR_W-1:0]          r_rr_ptr;
    logic [PTR_W-1:0]          r_owner;
    logic                      r_out_valid;
    logic                      r_out_head;
    logic                      r_out_tail;
    logic [EGRESS_BITS-1:0]    r_out_egress;
    logic [PAYLOAD_BITS-1:0]   r_out_payload;
    logic [CNT_BITS-1:0]       r_pkt_count;
    logic                      r_perr;

    logic [NUM_REQ-1:0]        w_cand;
    logic                      w_found;
    logic [PTR_W-1:0]          w_winner;
    logic [PTR_W-1:0]          w_sel;
    logic [PTR_W-1:0]          w_sel_inc;
    logic [NUM_REQ-1:0]        w_ready;
    logic                      w_slot_free;
    logic                      w_accept;
    logic                      w_sel_head;
    logic                      w_sel_tail;
    logic [EGRESS_BITS-1:0]    w_sel_egress;
    logic [PAYLOAD_BITS-1:0]   w_sel_payload;
    logic                      w_lone_nonhead;

    assign w_cand      = req_valid & req_head;
    assign w_slot_free = !r_out_valid || out_ready;

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        int w_idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_sel       = r_owner;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sel = w_winner;
                if (w_found && w_slot_free) w_ready[w_winner] = 1'b1;
            end
            ST_LOCKED: w_ready[r_owner] = w_slot_free;
            default: ;
        endcase
        if (!reset) w_ready = '0;
        w_accept = |(w_ready & req_valid);
        if (w_accept) begin
            if (r_state == ST_IDLE && !req_tail[w_sel])
                w_state_nxt = ST_LOCKED;
            else if (r_state == ST_LOCKED && req_tail[w_sel])
                w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_sel_egress  = '0;
        w_sel_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == PTR_W'(i)) begin
                w_sel_egress  = req_egress_id[i*EGRESS_BITS +: EGRESS_BITS];
                w_sel_payload = req_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign w_sel_head = req_head[w_sel];
    assign w_sel_tail = req_tail[w_sel];
    assign w_sel_inc  = (w_sel == PTR_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;

    // A lone non-head flit in IDLE can never be granted: flag it.
    assign w_lone_nonhead = (r_state == ST_IDLE) && $onehot(req_valid) && (w_cand == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_out_valid   <= 1'b0;
            r_out_head    <= 1'b0;
            r_out_tail    <= 1'b0;
            r_out_egress  <= '0;
            r_out_payload <= '0;
            r_pkt_count   <= '0;
            r_perr        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_head    <= w_sel_head;
                r_out_tail    <= w_sel_tail;
                r_out_egress  <= w_sel_egress;
                r_out_payload <= w_sel_payload;
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
            if (w_accept && r_state == ST_IDLE) r_owner <= w_winner;
            if (w_accept && w_sel_tail) begin
                r_rr_ptr    <= w_sel_inc;
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_lone_nonhead || (w_accept && r_state == ST_LOCKED && w_sel_head))
                r_perr <= 1'b1;
        end
    end

    assign req_ready      = w_ready;
    assign out_valid      = r_out_valid;
    assign out_head       = r_out_head;
    assign out_tail       = r_out_tail;
    assign out_egress_id  = r_out_egress;
    assign out_payload    = r_out_payload;
    assign pkt_count      = r_pkt_count;
    assign protocol_error = r_perr;

endmodule

// File: tb/tb_ingress_flit_arbiter.sv
// Directed bench for ingress_flit_arbiter: expected grants given per step,
// accepted flits queued in a scoreboard and matched against the output stage.
module tb_ingress_flit_arbiter;

    logic           clock;
    logic           reset;
    logic [3:0]     rv, rh, rt;
    logic [255:0]   reg_id, rpl;
    logic [3:0]     req_ready;
    logic           out_valid, out_head, out_tail;
    logic [63:0]    out_egress_id, out_payload;
    logic           out_ready;
    logic [31:0]    pkt_count;
    logic           protocol_error;

    typedef struct {
        logic        h;
        logic        t;
        logic [63:0] eg;
        logic [63:0] pl;
    } flit_t;

    flit_t q[$];
    int n_chk  = 0;
    int n_fail = 0;

    ingress_flit_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (rv),
        .req_head       (rh),
        .req_tail       (rt),
        .req_egress_id  (reg_id),
        .req_payload    (rpl),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_head       (out_head),
        .out_tail       (out_tail),
        .out_egress_id  (out_egress_id),
        .out_payload    (out_payload),
        .out_ready      (out_ready),
        .pkt_count      (pkt_count),
        .protocol_error (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic h, input logic t,
                           input logic [63:0] eg, input logic [63:0] p);
        rv[i] = v;
        rh[i] = h;
        rt[i] = t;
        reg_id[i*64 +: 64] = eg;
        rpl[i*64 +: 64]    = p;
    endtask

    // One clock: check grants, retire the shown flit, queue newly accepted ones.
    task automatic tick(input string tag, input logic [3:0] exp_ready);
        flit_t e;
        #1;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size()));
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ".out_head"}, 64'(out_head), 64'(e.h));
            chk({tag, ".out_tail"}, 64'(out_tail), 64'(e.t));
            chk({tag, ".out_egress"}, out_egress_id, e.eg);
            chk({tag, ".out_payload"}, out_payload, e.pl);
        end
        for (int i = 0; i < 4; i++) begin
            if (rv[i] && exp_ready[i]) begin
                e.h  = rh[i];
                e.t  = rt[i];
                e.eg = reg_id[i*64 +: 64];
                e.pl = rpl[i*64 +: 64];
                q.push_back(e);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset     = 1'b0;
        rv        = '0;
        rh        = '0;
        rt        = '0;
        reg_id    = '0;
        rpl       = '0;
        out_ready = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b1, 64'd1, 64'h11);
        #1;
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_payload", out_payload, 64'd0);
        chk("rst.out_egress", out_egress_id, 64'd0);
        chk("rst.pkt_count", 64'(pkt_count), 64'd0);
        chk("rst.perr", 64'(protocol_error), 64'd0);
        repeat (2) @(negedge clock);
        rv    = '0;
        reset = 1'b1;

        // Single-flit packet
        out_ready = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b1, 64'd3, 64'hA5);
        tick("single", 4'b0001);
        rv = '0;
        chk("single.pkt_count", 64'(pkt_count), 64'd1);
        tick("single.drain", 4'b0000);

        // Round robin with all four requesters continuously offering single-flit packets
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++)
                set_req(i, 1'b1, 1'b1, 1'b1, 64'(i), 64'(256 * k + i));
            tick("rr", 4'(1 << ((1 + k) % 4)));
        end
        chk("rr.pkt_count", 64'(pkt_count), 64'd9);
        rv = '0;
        tick("rr.drain", 4'b0000);

        // Packet lock: req1 four-flit packet while req2 waits with a head
        set_req(2, 1'b1, 1'b1, 1'b1, 64'd2, 64'hC0);
        set_req(1, 1'b1, 1'b1, 1'b0, 64'd1, 64'hB0);
        tick("lock.h", 4'b0010);
        set_req(1, 1'b1, 1'b0, 1'b0, 64'd1, 64'hB1);
        tick("lock.b1", 4'b0010);
        set_req(1, 1'b1, 1'b0, 1'b0, 64'd1, 64'hB2);
        tick("lock.b2", 4'b0010);
        set_req(1, 1'b1, 1'b0, 1'b1, 64'd1, 64'hB3);
        tick("lock.t", 4'b0010);
        rv[1] = 1'b0;
        tick("lock.next", 4'b0100);
        rv = '0;

        // Backpressure mid-packet on req3
        set_req(3, 1'b1, 1'b1, 1'b0, 64'd7, 64'hD0);
        tick("bp.h", 4'b1000);
        set_req(3, 1'b1, 1'b0, 1'b0, 64'd7, 64'hD1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("bp.stall", 4'b0000);
            chk("bp.hold_payload", out_payload, 64'hD0);
            chk("bp.hold_head", 64'(out_head), 64'd1);
        end
        out_ready = 1'b1;
        tick("bp.b1", 4'b1000);
        set_req(3, 1'b1, 1'b0, 1'b1, 64'd7, 64'hD2);
        tick("bp.t", 4'b1000);
        rv = '0;
        tick("bp.drain", 4'b0000);
        chk("bp.pkt_count", 64'(pkt_count), 64'd12);

        // Move rr_ptr away from 0, then abandon a req3 packet with reset
        set_req(1, 1'b1, 1'b1, 1'b1, 64'd1, 64'h61);
        tick("pre.g1", 4'b0010);
        rv = '0;
        set_req(3, 1'b1, 1'b1, 1'b0, 64'd3, 64'hE0);
        tick("mid.h", 4'b1000);
        set_req(3, 1'b1, 1'b0, 1'b0, 64'd3, 64'hE1);
        tick("mid.b", 4'b1000);
        #2;
        reset = 1'b0;
        #1;
        chk("mid.async_out_valid", 64'(out_valid), 64'd0);
        chk("mid.rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid.rst_pkt_count", 64'(pkt_count), 64'd0);
        q.delete();
        set_req(3, 1'b1, 1'b1, 1'b1, 64'd3, 64'hF3);
        set_req(0, 1'b1, 1'b1, 1'b1, 64'd0, 64'hF0);
        @(negedge clock);
        reset = 1'b1;
        tick("post.req0", 4'b0001);
        rv[0] = 1'b0;
        tick("post.req3", 4'b1000);
        rv = '0;
        tick("post.drain", 4'b0000);
        chk("post.pkt_count", 64'(pkt_count), 64'd2);

        // Lone non-head flit in IDLE
        chk("perr.before", 64'(protocol_error), 64'd0);
        set_req(2, 1'b1, 1'b0, 1'b0, 64'd2, 64'h77);
        tick("perr.nonhead", 4'b0000);
        chk("perr.set", 64'(protocol_error), 64'd1);
        rv = '0;
        tick("perr.idle1", 4'b0000);
        tick("perr.idle2", 4'b0000);
        chk("perr.sticky", 64'(protocol_error), 64'd1);
        set_req(2, 1'b1, 1'b1, 1'b1, 64'd2, 64'h78);
        tick("perr.head_ok", 4'b0100);
        rv = '0;
        tick("perr.drain", 4'b0000);
        chk("perr.still", 64'(protocol_error), 64'd1);
        reset = 1'b0;
        #1;
        chk("perr.cleared", 64'(protocol_error), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
